trellis_sched: RTL and testbench
================================

# trellis_sched

Per-symbol trellis sequencer for the hard-decision Viterbi decoder. It accepts one received 2-bit code symbol at a time and walks all 2^M destination states, one state per handshake beat. For each beat it presents the destination index, both predecessor states, and the hard-decision branch metric for each predecessor to the downstream ACS unit. It also owns the path-metric ping-pong bank select.

## Interface
- K, 5, constraint length
- M, K-1, state width
- G0_OCT, 'o23, generator 0 (tap i ↔ register bit i; register = {pred, b})
- G1_OCT, 'o35, generator 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- sym_valid  in  1  received symbol valid
- sym_ready  out  1  block can accept a symbol
- sym_in  in  2  received symbol; [1]=c0 (G0), [0]=c1 (G1)
- sym_first  in  1  symbol is first of a frame; qualified by sym_valid
- op_valid  out  1  ACS operation beat valid
- op_ready  in  1  ACS accepts beat
- op_dst  out  M  destination state
- op_pred0  out  M  predecessor with MSB 0
- op_pred1  out  M  predecessor with MSB 1
- op_bm0, op_bm1  out  2 each  Hamming distance (0..2) for pred0 and pred1 branches
- op_bank  out  1  path-metric read bank (write bank = ~op_bank)
- op_first  out  1  beat is dst 0 of its symbol
- op_last  out  1  beat is dst NS-1 of its symbol
- op_frame  out  1  latched sym_first of the current symbol (ACS uses initial metrics)
- busy  out  1  RUN state

## Operation
- Localparam NS = 1<<M. State machine has two states, IDLE and RUN. Registers: state, cnt[M-1:0], sym_q[1:0], frame_q, bank.
- Symbol handshake:
  - sym_ready = (state==IDLE) | (op_valid & op_ready & op_last).
  - Accept on sym_valid & sym_ready: sym_q←sym_in, frame_q←sym_first, cnt←0, state←RUN.
- RUN:
  - op_valid=1.
  - On op_valid & op_ready: if cnt!=NS-1 then cnt←cnt+1.
  - Otherwise this is the last beat: bank←~bank. Then go to RUN with cnt=0 if a new symbol is accepted in the same cycle; else go to IDLE.
- Beat decode from cnt (pure function of registers):
  - op_dst=cnt; b=cnt[0].
  - op_pred0={1'b0, cnt[M-1:1]}; op_pred1={1'b1, cnt[M-1:1]}.
  - exp_i = expected symbol of (pred_i, b).
  - op_bm_i = popcount(sym_q ^ exp_i).
  - op_first=(cnt==0); op_last=(cnt==NS-1); op_frame=frame_q.
- While op_valid & !op_ready, all op_* outputs hold stable.
- In IDLE: op_valid=0, busy=0. The other op_* outputs follow the registers and are don't-care to the consumer.
- bank toggles once per completed symbol only. It is never altered by sym_first.
- Reset (any time, including mid-symbol): state=IDLE, cnt=0, sym_q=0, frame_q=0, bank=0. Consequently op_valid=0, sym_ready=1, busy=0. A partial symbol is discarded, and bank does not toggle for it.

## Timing
- Symbol accepted at edge t → first beat (op_dst=0) valid in cycle t+1.
- Full throughput (op_ready held 1, sym_valid held 1): NS cycles per symbol with no bubble. The next symbol's dst 0 immediately follows dst NS-1.
- If no symbol is pending at the last beat: one IDLE cycle minimum before the next RUN.
- Beat outputs carry a combinational path only from flops. No combinational path exists from op_ready or sym_valid to any op_* output.
- sym_ready has a combinational path from op_ready; the consumer must not make op_ready depend on sym_ready.

## Structure
- viterbi_pkg holds the shared constants and types:
  - defaults for K, G0_OCT, G1_OCT;
  - function clog/NS helper;
  - typedef for the 2-bit symbol and 2-bit branch metric;
  - FSM state enum {IDLE, RUN}.
- Reuse expected_bits twice: (op_pred0, b) and (op_pred1, b).
- No new sub-module; Hamming distance is a local 2-bit popcount.

## Test plan
- Reset values: assert rst_n=0 mid-RUN (cnt=7) → next cycle op_valid=0, sym_ready=1, bank=0. After release, the new symbol starts at dst 0.
- K=5, sym_in=2'b10, op_ready=1 → beat dst=5 shows pred0=2, pred1=10, bm0=0, bm1=2 (exp 10 / 01).
- K=5, sym_in=2'b00 → beat dst=0 shows pred0=0, pred1=8, bm0=0, bm1=2, op_first=1; dst=15 shows op_last=1.
- Back-to-back: sym_valid held high for 3 symbols → exactly 48 consecutive valid beats. op_bank sequence is 0 (16 beats), 1, 0. sym_ready pulses only on beats with dst=15.
- Backpressure: random op_ready at 30% → every dst 0..15 appears exactly once per symbol in order, and outputs are stable while stalled.
- sym_first=1 on symbol 2 only → op_frame=1 on all 16 beats of symbol 2 and 0 elsewhere; bank toggling is unaffected.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants, types and helpers for the hard-decision Viterbi decoder.
package viterbi_pkg;

    // Default code: K=5, generators 23/35 octal.
    localparam int K_DEF  = 5;
    localparam int G0_DEF = 'o23;
    localparam int G1_DEF = 'o35;

    // Received / expected code symbol: [1]=c0 (G0), [0]=c1 (G1).
    typedef logic [1:0] sym_t;

    // Hard-decision branch metric, 0..2.
    typedef logic [1:0] bm_t;

    // Sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Number of trellis states for constraint length k.
    function automatic int num_states(input int k);
        return 1 << (k - 1);
    endfunction

    // Encoder output for shift register contents {pred, b}; tap i of each
    // generator multiplies register bit i.
    function automatic sym_t expected_bits(input logic [31:0] reg_val,
                                           input logic [31:0] g0,
                                           input logic [31:0] g1);
        return {^(reg_val & g0), ^(reg_val & g1)};
    endfunction

endpackage

// File: rtl/trellis_sched.sv
// Per-symbol trellis sequencer: walks every destination state once per
// received symbol and hands predecessor pairs plus branch metrics to the ACS.
module trellis_sched
    import viterbi_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int G0_OCT = G0_DEF,
    parameter int G1_OCT = G1_DEF,
    localparam int M     = K - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sym_valid,
    output logic         sym_ready,
    input  logic [1:0]   sym_in,
    input  logic         sym_first,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [M-1:0] op_dst,
    output logic [M-1:0] op_pred0,
    output logic [M-1:0] op_pred1,
    output logic [1:0]   op_bm0,
    output logic [1:0]   op_bm1,
    output logic         op_bank,
    output logic         op_first,
    output logic         op_last,
    output logic         op_frame,
    output logic         busy
);

    localparam int         NS       = num_states(K);
    localparam logic [M-1:0] CNT_LAST = M'(NS - 1);

    // Local 2-bit popcount of the symbol mismatch.
    function automatic bm_t hamming2(input sym_t a, input sym_t e);
        sym_t x;
        x = a ^ e;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    fsm_t         state;
    logic [M-1:0] cnt;
    sym_t         sym_q;
    logic         frame_q;
    logic         bank;

    logic         beat_done;
    logic         last_done;
    logic         accept;
    logic         b;
    sym_t         exp0;
    sym_t         exp1;

    // Handshake decode; only sym_ready sees op_ready combinationally.
    assign op_valid  = (state == RUN);
    assign busy      = op_valid;
    assign op_first  = (cnt == '0);
    assign op_last   = (cnt == CNT_LAST);
    assign beat_done = op_valid & op_ready;
    assign last_done = beat_done & op_last;
    assign sym_ready = (state == IDLE) | last_done;
    assign accept    = sym_valid & sym_ready;

    // Beat decode: pure function of registered state.
    assign op_dst   = cnt;
    assign b        = cnt[0];
    assign op_pred0 = {1'b0, cnt[M-1:1]};
    assign op_pred1 = {1'b1, cnt[M-1:1]};
    assign exp0     = expected_bits(32'({op_pred0, b}), 32'(G0_OCT), 32'(G1_OCT));
    assign exp1     = expected_bits(32'({op_pred1, b}), 32'(G0_OCT), 32'(G1_OCT));
    assign op_bm0   = hamming2(sym_q, exp0);
    assign op_bm1   = hamming2(sym_q, exp1);
    assign op_bank  = bank;
    assign op_frame = frame_q;

    // Sequencer FSM: symbol capture, beat counting and bank ping-pong.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sym_q   <= '0;
            frame_q <= 1'b0;
            bank    <= 1'b0;
        end else begin
            // A completed symbol swaps read/write path-metric banks.
            if (last_done) begin
                bank <= ~bank;
            end
            if (accept) begin
                sym_q   <= sym_in;
                frame_q <= sym_first;
                cnt     <= '0;
                state   <= RUN;
            end else if (last_done) begin
                state <= IDLE;
            end else if (beat_done) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trellis_sched.sv
// Randomized self-checking bench for trellis_sched with a behavioural
// convolutional-code reference model.
module tb_trellis_sched;

    localparam int K  = 5;
    localparam int M  = K - 1;
    localparam int NS = 1 << M;
    localparam int G0 = 'o23;
    localparam int G1 = 'o35;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sym_valid = 1'b0;
    logic         sym_ready;
    logic [1:0]   sym_in = 2'b00;
    logic         sym_first = 1'b0;
    logic         op_valid;
    logic         op_ready = 1'b0;
    logic [M-1:0] op_dst;
    logic [M-1:0] op_pred0;
    logic [M-1:0] op_pred1;
    logic [1:0]   op_bm0;
    logic [1:0]   op_bm1;
    logic         op_bank;
    logic         op_first;
    logic         op_last;
    logic         op_frame;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: the symbol being walked and its beat index.
    int       have_sym = 0;
    int       idx = 0;
    int       cur_sym = 0;
    int       cur_first = 0;
    int       completed = 0;
    int       accepted = 0;
    int       run_len = 0;
    int       last_run = 0;

    trellis_sched #(.K(K), .G0_OCT(G0), .G1_OCT(G1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_in    (sym_in),
        .sym_first (sym_first),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_dst    (op_dst),
        .op_pred0  (op_pred0),
        .op_pred1  (op_pred1),
        .op_bm0    (op_bm0),
        .op_bm1    (op_bm1),
        .op_bank   (op_bank),
        .op_first  (op_first),
        .op_last   (op_last),
        .op_frame  (op_frame),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Encoder output when input bit 'bit_in' is shifted into trellis state 'st'.
    function automatic int encode(input int st, input int bit_in);
        int regv;
        int c0;
        int c1;
        regv = st * 2 + bit_in;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < K; i++) begin
            if (((regv >> i) & 1) == 1) begin
                if (((G0 >> i) & 1) == 1) c0 = 1 - c0;
                if (((G1 >> i) & 1) == 1) c1 = 1 - c1;
            end
        end
        return c0 * 2 + c1;
    endfunction

    function automatic int distance(input int a, input int e);
        int n;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            if (((a >> i) & 1) != ((e >> i) & 1)) n++;
        end
        return n;
    endfunction

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input logic v, input logic [1:0] s, input logic f, input logic r);
        int d;
        int p0;
        int p1;
        int e_valid;
        int e_sready;
        @(posedge clk);
        #1;
        sym_valid = v;
        sym_in    = s;
        sym_first = f;
        op_ready  = r;
        #1;
        e_valid  = have_sym;
        e_sready = (have_sym == 0 || (r == 1'b1 && idx == NS - 1)) ? 1 : 0;
        check_eq("op_valid", int'(op_valid), e_valid);
        check_eq("busy", int'(busy), e_valid);
        check_eq("sym_ready", int'(sym_ready), e_sready);
        if (op_valid) begin
            run_len++;
        end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
        if (e_valid == 1) begin
            d  = idx;
            p0 = d / 2;
            p1 = d / 2 + NS / 2;
            check_eq("op_dst", int'(op_dst), d);
            check_eq("op_pred0", int'(op_pred0), p0);
            check_eq("op_pred1", int'(op_pred1), p1);
            check_eq("op_bm0", int'(op_bm0), distance(cur_sym, encode(p0, d % 2)));
            check_eq("op_bm1", int'(op_bm1), distance(cur_sym, encode(p1, d % 2)));
            check_eq("op_first", int'(op_first), (d == 0) ? 1 : 0);
            check_eq("op_last", int'(op_last), (d == NS - 1) ? 1 : 0);
            check_eq("op_frame", int'(op_frame), cur_first);
            check_eq("op_bank", int'(op_bank), completed % 2);
            if (cur_sym == 2 && d == 5) begin
                check_eq("dir10_pred0", int'(op_pred0), 2);
                check_eq("dir10_pred1", int'(op_pred1), 10);
                check_eq("dir10_bm0", int'(op_bm0), 0);
                check_eq("dir10_bm1", int'(op_bm1), 2);
            end
            if (cur_sym == 0 && d == 0) begin
                check_eq("dir00_pred1", int'(op_pred1), 8);
                check_eq("dir00_bm1", int'(op_bm1), 2);
                check_eq("dir00_first", int'(op_first), 1);
            end
        end
        if (e_valid == 1 && r == 1'b1) begin
            idx++;
            if (idx == NS) begin
                have_sym = 0;
                idx = 0;
                completed++;
            end
        end
        if (v == 1'b1 && e_sready == 1) begin
            have_sym  = 1;
            idx       = 0;
            cur_sym   = int'(s);
            cur_first = int'(f);
            accepted++;
            $display("symbol %0d accepted: sym=%b first=%0d bank=%0d", accepted, s, f, completed % 2);
        end
    endtask

    task automatic do_reset();
        sym_valid = 1'b0;
        sym_first = 1'b0;
        sym_in    = 2'b00;
        op_ready  = 1'b0;
        rst_n     = 1'b0;
        #1;
        have_sym  = 0;
        idx       = 0;
        completed = 0;
        run_len   = 0;
        check_eq("rst_op_valid", int'(op_valid), 0);
        check_eq("rst_sym_ready", int'(sym_ready), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_bank", int'(op_bank), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int hit;

        do_reset();

        // Directed symbols 10 and 00 at full rate.
        step(1'b1, 2'b10, 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b00, 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) step(1'b0, 2'b00, 1'b0, 1'b1);

        // Back-to-back: three symbols, frame flag on the second only.
        base = accepted;
        run_len = 0;
        last_run = 0;
        for (int n = 0; n < 60; n++) begin
            step((accepted - base) < 3, 2'($urandom), (accepted - base) == 1, 1'b1);
        end
        check_eq("b2b_beats", last_run, 3 * NS);

        // Random traffic with ~30% backpressure.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) >= 3);
        end
        for (int n = 0; n < 40; n++) step(1'b0, 2'b00, 1'b0, 1'b1);

        // Reset in the middle of a symbol at beat 7.
        hit = 0;
        for (int n = 0; n < 100 && hit == 0; n++) begin
            step(1'b1, 2'($urandom), 1'b0, 1'b1);
            if (have_sym == 1 && idx == 7) hit = 1;
        end
        check_eq("reach_beat7", hit, 1);
        @(posedge clk);
        #1;
        check_eq("pre_rst_dst", int'(op_dst), 7);
        do_reset();
        step(1'b1, 2'($urandom), 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) step(1'b0, 2'b00, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
